// File: rtl/hack_mem_arbiter.sv
// Data-RAM arbiter for the Hack computer: CPU has priority, a saturating wait
// counter guarantees the read-only DMA requester a slot within MAX_WAIT cycles.
module hack_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [15:0]       dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  // owner names the requester whose read data is on mem_rdata this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  owner_t           owner;
  logic [CNT_W-1:0] wait_cnt;
  logic             cpu_elig;
  logic             grant_cpu;
  logic             grant_dma;

  // A CPU read is never re-granted during its own data cycle.
  always_comb begin
    cpu_elig  = cpu_req & (owner != OWN_CPU);
    grant_dma = ~reset & dma_req & ((wait_cnt == WAIT_SAT) | ~cpu_elig);
    grant_cpu = ~reset & ~grant_dma & cpu_elig;
  end

  always_comb begin
    mem_en    = grant_cpu | grant_dma;
    mem_we    = grant_cpu & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant_dma) begin
      mem_addr  = dma_addr;
    end
  end

  assign dma_gnt    = grant_dma;
  assign cpu_done   = (grant_cpu & cpu_we) | (owner == OWN_CPU);
  assign cpu_stall  = cpu_req & ~cpu_done;
  assign dma_rvalid = (owner == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWN_NONE;
      wait_cnt <= '0;
    end else begin
      if (grant_dma)
        owner <= OWN_DMA;
      else if (grant_cpu & ~cpu_we)
        owner <= OWN_CPU;
      else
        owner <= OWN_NONE;

      if (~dma_req | grant_dma)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Bench for hack_mem_arbiter: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a behavioural arbitration model.
module tb_hack_mem_arbiter;

  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic [15:0]       cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [15:0]       dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  hack_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 40503) ^ 16'h5a5a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM driven by the DUT's memory port (1-cycle read latency)
  bit   [15:0] ram [DEPTH];
  bit          ram_wr [DEPTH];
  logic [15:0] ram_q;
  assign mem_rdata = ram_q;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q <= 16'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        ram_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
      end
    end
  end

  // Behavioural model: who gets data next cycle, how long DMA has been denied,
  // and what the memory should contain.
  int          m_pend;    // 0 none, 1 cpu, 2 dma
  int          m_denied;
  logic [15:0] m_pend_data;
  bit   [15:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          n_pend = 0;
  int          n_denied = 0;
  logic [15:0] n_data = 16'h0;
  logic        n_wr = 1'b0;
  logic [ADDR_W-1:0] n_waddr = '0;
  logic [15:0] n_wdata = 16'h0;
  logic        m_done_q = 1'b0;

  function automatic logic [15:0] model_read(input logic [ADDR_W-1:0] a);
    return m_wr[a] ? m_mem[a] : init_val(int'(a));
  endfunction

  always @(negedge clk) begin : cmp
    logic elig;
    int   g;
    logic e_done;
    logic [ADDR_W-1:0] e_addr;
    elig = cpu_req && (m_pend != 1);
    if (reset) g = 0;
    else if (dma_req && (m_denied >= MAX_WAIT || !elig)) g = 2;
    else if (elig) g = 1;
    else g = 0;
    e_addr = (g == 1) ? cpu_addr : (g == 2) ? dma_addr : '0;
    e_done = (g == 1 && cpu_we) || (m_pend == 1);
    chk("mem_en", 32'(mem_en), 32'(g != 0));
    chk("mem_we", 32'(mem_we), 32'(g == 1 && cpu_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (g != 2) chk("mem_wdata", 32'(mem_wdata), (g == 1) ? 32'(cpu_wdata) : 32'h0);
    chk("dma_gnt", 32'(dma_gnt), 32'(g == 2));
    chk("cpu_done", 32'(cpu_done), 32'(e_done));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_done));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_pend == 2));
    if (m_pend == 1) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_pend_data));
    if (m_pend == 2) chk("dma_rdata", 32'(dma_rdata), 32'(m_pend_data));
    n_pend   = (g == 2) ? 2 : (g == 1 && !cpu_we) ? 1 : 0;
    n_data   = model_read(e_addr);
    n_wr     = (g == 1) && cpu_we;
    n_waddr  = cpu_addr;
    n_wdata  = cpu_wdata;
    n_denied = (dma_req && g != 2) ? ((m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT) : 0;
    m_done_q = e_done;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend   <= 0;
      m_denied <= 0;
    end else begin
      m_pend      <= n_pend;
      m_denied    <= n_denied;
      m_pend_data <= n_data;
      if (n_wr) begin
        m_mem[n_waddr] <= n_wdata;
        m_wr[n_waddr]  <= 1'b1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0;

    // Reset with random inputs: grants must stay off
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = ADDR_W'($urandom); cpu_wdata = 16'($urandom);
      dma_req = 1'($urandom); dma_addr = ADDR_W'($urandom);
      @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_dma_gnt", 32'(dma_gnt), 32'h0);
    end
    next_cycle();
    cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0;
    @(negedge clk);
    chk("rst_all_outputs", {cpu_rdata, 6'h0, cpu_done, cpu_stall, dma_gnt, dma_rvalid,
                            mem_en, mem_we, mem_addr == '0, mem_wdata == '0, 2'b0},
        {16'h0, 6'h0, 8'h0, 1'b1, 1'b1, 2'b0});
    chk("rst_dma_rdata", 32'(dma_rdata), 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(cpu_done), 32'h0);
    chk("post_rst_rvalid", 32'(dma_rvalid), 32'h0);

    // Uncontended write
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_mem_en", 32'(mem_en), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_done", 32'(cpu_done), 32'h1);
    chk("wr_stall", 32'(cpu_stall), 32'h0);

    // Read back: one stall cycle, then data
    next_cycle();
    cpu_we = 1'b0;
    @(negedge clk);
    chk("rd0_mem_en", 32'(mem_en), 32'h1);
    chk("rd0_mem_we", 32'(mem_we), 32'h0);
    chk("rd0_stall", 32'(cpu_stall), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("rd1_done", 32'(cpu_done), 32'h1);
    chk("rd1_rdata", 32'(cpu_rdata), 32'h1234);
    chk("rd1_mem_en", 32'(mem_en), 32'h0);
    next_cycle();
    cpu_req = 1'b0;

    // Starvation bound: CPU writes back to back, DMA holds its request
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ADDR_W'(14'h0100 + c);
      cpu_wdata = 16'($urandom); dma_req = 1'b1; dma_addr = 14'h1000;
      @(negedge clk);
      if (c < 4) begin
        chk("starve_cpu_done", 32'(cpu_done), 32'h1);
        chk("starve_no_gnt", 32'(dma_gnt), 32'h0);
      end else if (c == 4) begin
        chk("starve_dma_gnt", 32'(dma_gnt), 32'h1);
        chk("starve_dma_addr", 32'(mem_addr), 32'h1000);
        chk("starve_stall", 32'(cpu_stall), 32'h1);
      end else begin
        chk("starve_rvalid", 32'(dma_rvalid), 32'h1);
        chk("starve_cpu_back", 32'(cpu_done), 32'h1);
        chk("starve_cnt_clear", 32'(dma_gnt), 32'h0);
      end
    end
    next_cycle();
    cpu_req = 1'b0; dma_req = 1'b0;

    // Overlap: DMA takes the CPU read's data cycle
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
    dma_req = 1'b1; dma_addr = 14'h0abc;
    @(negedge clk);
    chk("ovl0_addr", 32'(mem_addr), 32'h20);
    chk("ovl0_gnt", 32'(dma_gnt), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("ovl1_done", 32'(cpu_done), 32'h1);
    chk("ovl1_rdata", 32'(cpu_rdata), 32'(init_val(32'h20)));
    chk("ovl1_gnt", 32'(dma_gnt), 32'h1);
    chk("ovl1_addr", 32'(mem_addr), 32'h0abc);
    next_cycle();
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("ovl2_rvalid", 32'(dma_rvalid), 32'h1);
    chk("ovl2_rdata", 32'(dma_rdata), 32'(init_val(32'h0abc)));

    // Reset during the data cycle of a CPU read
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0030;
    @(negedge clk);
    chk("rmr_grant", 32'(mem_en), 32'h1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rmr_done_drop", 32'(cpu_done), 32'h0);
    chk("rmr_rvalid", 32'(dma_rvalid), 32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rmr_regrant", 32'(mem_en), 32'h1);
    chk("rmr_no_done", 32'(cpu_done), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rmr_done", 32'(cpu_done), 32'h1);
    chk("rmr_rdata", 32'(cpu_rdata), 32'(init_val(32'h30)));
    next_cycle();
    cpu_req = 1'b0;

    // Randomized traffic on a small address window to force read-after-write hits
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset = ($urandom_range(0, 249) == 0);
      if (!cpu_req || m_done_q) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = 1'($urandom);
        cpu_addr  = ADDR_W'($urandom_range(0, 63));
        cpu_wdata = 16'($urandom);
      end
      dma_req  = ($urandom_range(0, 3) != 0);
      dma_addr = ADDR_W'($urandom_range(0, 63));
    end
    next_cycle();
    reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_mem_arbiter.md
# hack_mem_arbiter

Single-port data-RAM arbiter for the Hack computer. It shares one synchronous data RAM (1-cycle read latency) between the HackCPU data port and a read-only DMA requester, such as a screen-refresh or scan-out engine. The CPU has priority. A wait counter guarantees the DMA a slot after a bounded number of cycles. The block stalls the CPU while its access is outstanding and returns read data to the correct owner.

## Interface
- ADDR_W, 14, RAM word-address width (16K words)
- MAX_WAIT, 4, number of consecutive denied DMA cycles after which the DMA wins arbitration (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request; held high until cpu_done
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  read data; qualified by cpu_done on a read
- cpu_done  out  1  access complete (write: grant cycle; read: data cycle)
- cpu_stall  out  1  cpu_req high and cpu_done low
- dma_req  in  1  DMA read request; may be held for back-to-back reads
- dma_addr  in  ADDR_W  DMA word address
- dma_gnt  out  1  DMA address accepted this cycle
- dma_rvalid  out  1  dma_rdata valid; asserted 1 cycle after dma_gnt
- dma_rdata  out  16  DMA read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data; valid 1 cycle after mem_en with mem_we=0

## Operation
- **Registered state**
  - `owner` ∈ {NONE, CPU, DMA}: requester whose read data returns this cycle.
  - `wait_cnt`: 0..MAX_WAIT.
- **CPU eligibility:** cpu_elig = cpu_req & (owner != CPU). A CPU read is not re-granted during its own data cycle.
- **Grant rule, evaluated each cycle:**
  - If dma_req & (wait_cnt == MAX_WAIT | ~cpu_elig), grant DMA.
  - Otherwise, if cpu_elig, grant CPU.
  - Otherwise, grant nobody.
- **CPU grant:** mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - Write: cpu_done=1 in the grant cycle. The next owner is NONE.
  - Read: the next owner is CPU.
- **DMA grant:** mem_en=1, mem_we=0, mem_addr=dma_addr, dma_gnt=1. The next owner is DMA.
- **No grant:** mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. The next owner is NONE.
- **Data cycle:**
  - owner==CPU: cpu_done=1.
  - owner==DMA: dma_rvalid=1.
  - cpu_rdata and dma_rdata both pass mem_rdata through directly. Consumers qualify them with cpu_done or dma_rvalid.
- **wait_cnt:**
  - Clears to 0 when dma_gnt is high or dma_req is low.
  - Increments when dma_req is high and dma_gnt is low.
  - Saturates at MAX_WAIT.
- **Overlap:** a new grant may issue in the same cycle as the previous read's data cycle, so the RAM pipeline is fully used.
- **Simultaneous events:**
  - CPU write plus DMA at wait_cnt<MAX_WAIT: CPU wins.
  - CPU read data cycle plus dma_req: DMA is granted, because the CPU is not eligible.
- **Mid-transfer changes:** dropping dma_req after a grant still produces dma_rvalid next cycle. Dropping cpu_req in a CPU read's data cycle still produces cpu_done; the CPU ignores it.

## Timing
- **Reset (asynchronous, immediate):** owner=NONE, wait_cnt=0. All outputs are 0 while reset is high with requests low; the grant outputs stay 0 while reset is asserted.
- **Reset during a pending read:** the read is discarded. No cpu_done or dma_rvalid appears after reset releases.
- **Combinational paths:** mem_*, dma_gnt, cpu_stall and cpu_done are combinational from the registered state and current inputs.
- **Registered path:** dma_rvalid depends only on registered owner.
- **Latency:**
  - CPU write: 0 extra cycles when uncontended.
  - CPU read: 1 stall cycle; cpu_done comes 1 cycle after grant.
  - DMA read: data 1 cycle after dma_gnt.
- **Worst-case DMA wait:** MAX_WAIT cycles from the first requesting cycle to grant (grant occurs in cycle MAX_WAIT+1).
- **Worst-case CPU wait:** 1 cycle, because the counter clears after each DMA grant.

## Test plan
- **Reset:** assert reset with random inputs, then release with requests low. All outputs are 0; the first cycle after release has no cpu_done or dma_rvalid.
- **Uncontended CPU write:** write addr 0x0010, data 0x1234. In the same cycle mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x1234, cpu_done=1, cpu_stall=0.
- **CPU read:** read 0x0010 with the RAM model returning 0x1234. Cycle 0 gives mem_en=1, mem_we=0, cpu_stall=1. Cycle 1 gives cpu_done=1, cpu_rdata=0x1234, mem_en=0.
- **Starvation bound:** CPU writes every cycle while DMA holds dma_req at addr 0x1000, MAX_WAIT=4. Cycles 0–3 are CPU grants; cycle 4 gives dma_gnt=1; cycle 5 gives dma_rvalid=1 and a CPU grant, with wait_cnt back to 0.
- **Overlap:** CPU read 0x0020 while dma_req is high at wait_cnt=0. Cycle 0 is a CPU grant. Cycle 1 gives cpu_done=1, dma_gnt=1 and mem_addr=dma_addr. Cycle 2 gives dma_rvalid=1.
- **Reset mid-read:** grant a CPU read, then assert reset in the data cycle. cpu_done drops immediately; after release, no cpu_done or dma_rvalid appears and the CPU re-request is granted normally.
